// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback sources and register-file write port bundle
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              init_done;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, rf_reg_write, rf_write_reg, rf_write_data, init_done
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, rf_reg_write, rf_write_reg, rf_write_data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - zero-fills the register file, then arbitrates A/B writebacks
module regfile_write_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_MAX = 4'(MAX_WAIT);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [3:0]        wait_cnt;
    logic              in_run;
    logic              starved;
    logic              b_pri;
    logic              grant_b;
    logic              a_xfer;
    logic              b_xfer;

    // B is allowed onto the port whenever A is idle or B has waited long enough.
    always_comb begin
        in_run  = (state == RUN);
        starved = (wait_cnt == WAIT_MAX);
        b_pri   = ~bus.a_valid | starved;
        grant_b = bus.b_valid & b_pri;
        a_xfer  = in_run & bus.a_valid & ~grant_b;
        b_xfer  = in_run & grant_b;
    end

    assign bus.a_ready = in_run & ~grant_b;
    assign bus.b_ready = in_run & b_pri;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= INIT;
            init_cnt          <= ADDR_W'(1);
            wait_cnt          <= '0;
            bus.rf_reg_write  <= 1'b0;
            bus.rf_write_reg  <= '0;
            bus.rf_write_data <= '0;
            bus.init_done     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    bus.rf_reg_write  <= 1'b1;
                    bus.rf_write_reg  <= init_cnt;
                    bus.rf_write_data <= '0;
                    init_cnt          <= init_cnt + 1'b1;
                    if (init_cnt == LAST_REG) begin
                        bus.init_done <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    // r0 writes complete the handshake but never raise the enable.
                    if (a_xfer) begin
                        bus.rf_reg_write  <= (bus.a_reg != '0);
                        bus.rf_write_reg  <= bus.a_reg;
                        bus.rf_write_data <= bus.a_data;
                    end else if (b_xfer) begin
                        bus.rf_reg_write  <= (bus.b_reg != '0);
                        bus.rf_write_reg  <= bus.b_reg;
                        bus.rf_write_data <= bus.b_data;
                    end else begin
                        bus.rf_reg_write  <= 1'b0;
                    end

                    if (!bus.b_valid || b_xfer) begin
                        wait_cnt <= '0;
                    end else if (!starved) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and random checks of regfile_write_arbiter against a reference model
module tb_regfile_write_arbiter;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Reference model state: expected write port and how long B has been kept waiting.
    int          m_stall = 0;
    logic        m_we    = 1'b0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   32'(bus.rf_reg_write), 32'd0);
        check({tag, "_reg"},  32'(bus.rf_write_reg), 32'd0);
        check({tag, "_data"}, bus.rf_write_data, 32'd0);
        check({tag, "_done"}, 32'(bus.init_done), 32'd0);
        check({tag, "_ardy"}, 32'(bus.a_ready), 32'd0);
        check({tag, "_brdy"}, 32'(bus.b_ready), 32'd0);
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    endtask

    // Called at posedge+1 with rst just released: expects the full zero-fill sweep.
    task automatic run_init();
        for (int k = 1; k < NUM_REGS; k++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            #1;
            check("init_ardy", 32'(bus.a_ready), 32'd0);
            check("init_brdy", 32'(bus.b_ready), 32'd0);
            @(posedge clk); #1;
            check("init_we",   32'(bus.rf_reg_write), 32'd1);
            check("init_reg",  32'(bus.rf_write_reg), 32'(k));
            check("init_data", bus.rf_write_data, 32'd0);
            check("init_done", 32'(bus.init_done), 32'(k == NUM_REGS - 1));
        end
        m_stall = 0;
        m_we    = 1'b0;
        m_reg   = 5'(NUM_REGS - 1);
        m_data  = '0;
    endtask

    // One RUN cycle: A has priority unless B has already waited MAX_WAIT cycles.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bit b_turn;
        bit a_win;
        bit b_win;
        drive(av, ar, ad, bv, br, bd);
        #1;
        b_turn = !av || (m_stall >= MAX_WAIT);
        b_win  = bv && b_turn;
        a_win  = av && !b_win;
        check("a_ready", 32'(bus.a_ready), 32'(!b_win));
        check("b_ready", 32'(bus.b_ready), 32'(b_turn));
        if (a_win) begin
            m_we = (ar != 0); m_reg = ar; m_data = ad;
        end else if (b_win) begin
            m_we = (br != 0); m_reg = br; m_data = bd;
        end else begin
            m_we = 1'b0;
        end
        if (bv && !b_win) m_stall++;
        else m_stall = 0;
        @(posedge clk); #1;
        check("rf_we",   32'(bus.rf_reg_write), 32'(m_we));
        check("rf_reg",  32'(bus.rf_write_reg), 32'(m_reg));
        check("rf_data", bus.rf_write_data, m_data);
        check("done",    32'(bus.init_done), 32'd1);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        check_all_zero("por");
        @(posedge clk); #1;
        rst = 1'b0;
        run_init();

        // idle cycle after fill: enable must drop
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("t2_data", bus.rf_write_data, 32'hDEADBEEF);

        // both sources saturated: pattern AAAAB from a fresh wait count
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'd5, 32'(i), 1'b1, 5'd6, 32'(100 + i));
            check("t3_winner", 32'(bus.rf_write_reg), (i % 5 == 4) ? 32'd6 : 32'd5);
        end

        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        check("t4_r0_we", 32'(bus.rf_reg_write), 32'd0);

        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0B0B);
        check("t6_b_reg", 32'(bus.rf_write_reg), 32'd7);
        cycle(1'b1, 5'd9, 32'h0A0A, 1'b0, 5'd0, 32'd0);
        check("t6_a_reg", 32'(bus.rf_write_reg), 32'd9);

        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
        end

        // reset at INIT edge 10
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_run");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
        end
        #1;
        check("pre_rst_reg", 32'(bus.rf_write_reg), 32'd10);
        rst = 1'b1;
        #1;
        check_all_zero("rst_init");
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        run_init();

        // reset with an accept in flight: the accepted write must never appear
        drive(1'b1, 5'd3, 32'hCAFEF00D, 1'b0, '0, '0);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_xfer");
        @(posedge clk); #1;
        rst = 1'b0;
        run_init();

        for (int i = 0; i < 100; i++) begin
            cycle(1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 3) != 0), 5'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
